// File: rtl/rob_commit_ctrl_pkg.sv
// Shared commit-stage types: commit FSM state encoding and the per-slot ROB head view.
// Pure declarations; no logic, no latency.
// Used by the commit controller and anything else that needs the ROB head packet layout.
package rob_commit_ctrl_pkg;

  // Default retire width (number of ROB head slots inspected per cycle)
  localparam int RETIRE_W_DEF = 3;

  // Commit sequencer states
  typedef enum logic [1:0] {
    CM_RUN     = 2'd0,
    CM_ST_WAIT = 2'd1,
    CM_FLUSH   = 2'd2,
    CM_HALTED  = 2'd3
  } COMMIT_STATE;

  // One ROB head slot as seen by the commit stage
  typedef struct packed {
    logic valid;
    logic complete;
    logic is_store;
    logic mispred;
    logic halt;
  } ROB_HEAD_PACKET;

  // Slot holds an instruction that has finished executing
  function automatic logic slot_done(input ROB_HEAD_PACKET p);
    return p.valid & p.complete;
  endfunction

  // Slot may retire inside a normal group (stores go through the handshake instead)
  function automatic logic slot_eligible(input ROB_HEAD_PACKET p);
    return p.valid & p.complete & ~p.is_store;
  endfunction

  // Slot closes the retire group (later slots must wait for the flush/halt)
  function automatic logic slot_stops_group(input ROB_HEAD_PACKET p);
    return p.mispred | p.halt;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_retire_prefix_mask.sv
// Turns per-slot eligibility into a contiguous retire prefix and its population count.
// Purely combinational, zero latency.
// No handshake; the caller decides when the mask is used.
module retire_prefix_mask #(
  parameter int N    = 3,
  parameter int NR_W = $clog2(N + 1)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [N-1:0]    stop_after_i,
  output logic [N-1:0]    retire_valid_o,
  output logic [NR_W-1:0] num_retire_o
);

  logic alive;

  // Walk slots oldest-first; a slot retires only if every older slot did and none closed the group
  always_comb begin
    alive          = 1'b1;
    retire_valid_o = '0;
    num_retire_o   = '0;
    for (int i = 0; i < N; i++) begin
      retire_valid_o[i] = alive & eligible_i[i];
      num_retire_o      = num_retire_o + NR_W'(retire_valid_o[i]);
      alive             = retire_valid_o[i] & ~stop_after_i[i];
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retirement sequencer at the ROB head: retire mask/count, store commit handshake,
// mispredict flush pulse and sticky halt. Retire decision is zero-latency from the head inputs.
// Stores stall retirement until st_ack_i; flush and halt states ignore the head inputs.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter  int N     = RETIRE_W_DEF,
  parameter  int CNT_W = 32,
  localparam int NR_W  = $clog2(N + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [N-1:0]     head_valid_i,
  input  logic [N-1:0]     head_complete_i,
  input  logic [N-1:0]     head_is_store_i,
  input  logic [N-1:0]     head_mispred_i,
  input  logic [N-1:0]     head_halt_i,
  input  logic             st_ack_i,
  output logic [N-1:0]     retire_valid_o,
  output logic [NR_W-1:0]  num_retire_o,
  output logic             st_req_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_total_o
);

  COMMIT_STATE    state_q, state_d;
  ROB_HEAD_PACKET head_pkt [N];

  logic [N-1:0]     eligible;
  logic [N-1:0]     stop_after;
  logic [N-1:0]     run_retire_valid;
  logic [NR_W-1:0]  run_num_retire;
  logic             slot0_store_ready;
  logic             halt_hit;
  logic             mispred_hit;
  logic [CNT_W-1:0] retired_total_q, retired_total_d;

  // Gather the per-slot head signals into packets and derive eligibility / group-stop masks
  always_comb begin
    eligible   = '0;
    stop_after = '0;
    for (int i = 0; i < N; i++) begin
      head_pkt[i].valid    = head_valid_i[i];
      head_pkt[i].complete = head_complete_i[i];
      head_pkt[i].is_store = head_is_store_i[i];
      head_pkt[i].mispred  = head_mispred_i[i];
      head_pkt[i].halt     = head_halt_i[i];
      eligible[i]          = slot_eligible(head_pkt[i]);
      stop_after[i]        = slot_stops_group(head_pkt[i]);
    end
  end

  retire_prefix_mask #(
    .N    (N),
    .NR_W (NR_W)
  ) u_prefix (
    .eligible_i     (eligible),
    .stop_after_i   (stop_after),
    .retire_valid_o (run_retire_valid),
    .num_retire_o   (run_num_retire)
  );

  // A store only enters the handshake once it is the oldest entry and has completed
  assign slot0_store_ready = slot_done(head_pkt[0]) & head_pkt[0].is_store;

  // Only the last retiring slot can carry these flags, so an OR over the group is exact
  assign halt_hit    = |(run_retire_valid & head_halt_i);
  assign mispred_hit = |(run_retire_valid & head_mispred_i);

  // State register; reset returns to RUN, abandoning any pending store
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= CM_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision; halt takes priority over mispredict when both close the group
  always_comb begin
    state_d = state_q;
    case (state_q)
      CM_RUN: begin
        if (slot0_store_ready) begin
          state_d = CM_ST_WAIT;
        end else if (halt_hit) begin
          state_d = CM_HALTED;
        end else if (mispred_hit) begin
          state_d = CM_FLUSH;
        end
      end
      CM_ST_WAIT: begin
        if (st_ack_i) begin
          state_d = head_mispred_i[0] ? CM_FLUSH : CM_RUN;
        end
      end
      CM_FLUSH:  state_d = CM_RUN;
      CM_HALTED: state_d = CM_HALTED;
      default:   state_d = CM_RUN;
    endcase
  end

  // Output decode per state; everything is held low while reset is asserted
  always_comb begin
    retire_valid_o = '0;
    num_retire_o   = '0;
    st_req_o       = 1'b0;
    flush_o        = 1'b0;
    halted_o       = 1'b0;
    if (reset_i) begin
      case (state_q)
        CM_RUN: begin
          retire_valid_o = run_retire_valid;
          num_retire_o   = run_num_retire;
        end
        CM_ST_WAIT: begin
          st_req_o = 1'b1;
          if (st_ack_i) begin
            retire_valid_o    = '0;
            retire_valid_o[0] = 1'b1;
            num_retire_o      = NR_W'(1);
          end
        end
        CM_FLUSH:  flush_o  = 1'b1;
        CM_HALTED: halted_o = 1'b1;
        default: begin
          retire_valid_o = '0;
        end
      endcase
    end
  end

  // Running retired-instruction count; wraps naturally at the counter width
  always_comb begin
    retired_total_d = retired_total_q + CNT_W'(num_retire_o);
  end

  // Counter register
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      retired_total_q <= '0;
    end else begin
      retired_total_q <= retired_total_d;
    end
  end

  assign retired_total_o = retired_total_q;

endmodule
